// File: rtl/isdu_ctrl.sv
// SLC-3 instruction sequencing/decode FSM: fetch, decode and execute of the reduced LC-3 set.
// Control outputs are registered from the next state, so they always reflect the current state.
module isdu_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33_1, S33_2, S35, S32,
        S01, S05, S09, S00, S22, S12,
        S04, S21, S20,
        S06, S25_1, S25_2, S27,
        S07, S23, S16_1, S16_2,
        PAUSE1, PAUSE2
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2_imm_en;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctl_t;

    localparam logic [1:0] PC_INC   = 2'b00;
    localparam logic [1:0] PC_ADDER = 2'b10;
    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    state_t r_state;
    state_t w_nxt;
    ctl_t   r_ctl;

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c        = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        case (s)
            S18: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.pcmux   = PC_INC;
                c.ld_pc   = 1'b1;
            end
            S33_1: c.mem_oe = 1'b0;
            S33_2: begin
                c.mem_oe = 1'b0;
                c.ld_mdr = 1'b1;
            end
            S35: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S32: c.ld_ben = 1'b1;
            S01, S05: begin
                c.sr2_imm_en = 1'b1;
                c.aluk       = (s == S05) ? ALU_AND : ALU_ADD;
                c.gate_alu   = 1'b1;
                c.ld_reg     = 1'b1;
                c.ld_cc      = 1'b1;
            end
            S09: begin
                c.aluk     = ALU_NOT;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S22: begin
                c.addr1mux = 1'b0;
                c.addr2mux = A2_OFF9;
                c.pcmux    = PC_ADDER;
                c.ld_pc    = 1'b1;
            end
            S12, S20: begin
                c.addr1mux = 1'b1;
                c.addr2mux = A2_ZERO;
                c.pcmux    = PC_ADDER;
                c.ld_pc    = 1'b1;
            end
            S04: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b1;
                c.ld_reg  = 1'b1;
            end
            S21: begin
                c.addr1mux = 1'b0;
                c.addr2mux = A2_OFF11;
                c.pcmux    = PC_ADDER;
                c.ld_pc    = 1'b1;
            end
            S06, S07: begin
                c.addr1mux    = 1'b1;
                c.addr2mux    = A2_OFF6;
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
            end
            S25_1: c.mem_oe = 1'b0;
            S25_2: begin
                c.mem_oe = 1'b0;
                c.ld_mdr = 1'b1;
            end
            S27: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S23: begin
                c.sr1mux   = 1'b1;
                c.aluk     = ALU_PASS;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
            end
            S16_1, S16_2: c.mem_we = 1'b0;
            PAUSE1: c.ld_led = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            HALTED: if (Run) w_nxt = S18;
            S18:    w_nxt = S33_1;
            S33_1:  w_nxt = S33_2;
            S33_2:  w_nxt = S35;
            S35:    w_nxt = S32;
            S32: begin
                case (Opcode)
                    4'b0001: w_nxt = S01;
                    4'b0101: w_nxt = S05;
                    4'b1001: w_nxt = S09;
                    4'b0000: w_nxt = S00;
                    4'b1100: w_nxt = S12;
                    4'b0100: w_nxt = S04;
                    4'b0110: w_nxt = S06;
                    4'b0111: w_nxt = S07;
                    4'b1101: w_nxt = PAUSE1;
                    default: w_nxt = S18;
                endcase
            end
            S00:    w_nxt = BEN ? S22 : S18;
            S04:    w_nxt = IR_11 ? S21 : S20;
            S06:    w_nxt = S25_1;
            S25_1:  w_nxt = S25_2;
            S25_2:  w_nxt = S27;
            S07:    w_nxt = S23;
            S23:    w_nxt = S16_1;
            S16_1:  w_nxt = S16_2;
            PAUSE1: if (Continue) w_nxt = PAUSE2;
            PAUSE2: if (!Continue) w_nxt = S18;
            default: w_nxt = S18;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= HALTED;
            r_ctl   <= decode(HALTED);
        end else begin
            r_state <= w_nxt;
            r_ctl   <= decode(w_nxt);
        end
    end

    assign LD_MAR     = r_ctl.ld_mar;
    assign LD_MDR     = r_ctl.ld_mdr;
    assign LD_IR      = r_ctl.ld_ir;
    assign LD_BEN     = r_ctl.ld_ben;
    assign LD_CC      = r_ctl.ld_cc;
    assign LD_REG     = r_ctl.ld_reg;
    assign LD_PC      = r_ctl.ld_pc;
    assign LD_LED     = r_ctl.ld_led;
    assign GatePC     = r_ctl.gate_pc;
    assign GateMDR    = r_ctl.gate_mdr;
    assign GateALU    = r_ctl.gate_alu;
    assign GateMARMUX = r_ctl.gate_marmux;
    assign PCMUX      = r_ctl.pcmux;
    assign DRMUX      = r_ctl.drmux;
    assign SR1MUX     = r_ctl.sr1mux;
    // IR is stable through execute, so following IR_5 live keeps the immediate select exact
    assign SR2MUX     = r_ctl.sr2_imm_en & IR_5;
    assign ADDR1MUX   = r_ctl.addr1mux;
    assign ADDR2MUX   = r_ctl.addr2mux;
    assign ALUK       = r_ctl.aluk;
    assign Mem_OE     = r_ctl.mem_oe;
    assign Mem_WE     = r_ctl.mem_we;

endmodule

// File: tb/tb_isdu_ctrl.sv
// Self-checking bench for isdu_ctrl: per-cycle control words compared against an
// instruction-level model of fetch/execute micro-sequences.
module tb_isdu_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

    isdu_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    typedef logic [23:0] cw_t;
    cw_t w_obs;
    assign w_obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                    GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                    SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    localparam cw_t DEF      = 24'h000003;
    localparam cw_t LDMAR    = 24'h800000;
    localparam cw_t LDMDR    = 24'h400000;
    localparam cw_t LDIR     = 24'h200000;
    localparam cw_t LDBEN    = 24'h100000;
    localparam cw_t LDCC     = 24'h080000;
    localparam cw_t LDREG    = 24'h040000;
    localparam cw_t LDPC     = 24'h020000;
    localparam cw_t LDLED    = 24'h010000;
    localparam cw_t GPC      = 24'h008000;
    localparam cw_t GMDR     = 24'h004000;
    localparam cw_t GALU     = 24'h002000;
    localparam cw_t GMM      = 24'h001000;
    localparam cw_t PC_ADDR  = 24'h000800;
    localparam cw_t DRM      = 24'h000200;
    localparam cw_t SR1      = 24'h000100;
    localparam cw_t SR2      = 24'h000080;
    localparam cw_t A1       = 24'h000040;
    localparam cw_t A2_OFF6  = 24'h000010;
    localparam cw_t A2_OFF9  = 24'h000020;
    localparam cw_t A2_OFF11 = 24'h000030;
    localparam cw_t ALU_AND  = 24'h000004;
    localparam cw_t ALU_NOT  = 24'h000008;
    localparam cw_t ALU_PASS = 24'h00000C;
    localparam cw_t RD       = 24'h000001;  // Mem_OE low
    localparam cw_t WR       = 24'h000002;  // Mem_WE low
    localparam cw_t FETCH0   = DEF | GPC | LDMAR | LDPC;

    int   n_cmp  = 0;
    int   n_fail = 0;
    cw_t  q_exp[$];

    // Expected control word for every cycle of one instruction, starting at fetch.
    function automatic void build(input int op, input bit ir5, input bit ir11, input bit ben);
        q_exp.delete();
        q_exp.push_back(FETCH0);
        q_exp.push_back(RD);
        q_exp.push_back(RD | LDMDR);
        q_exp.push_back(DEF | GMDR | LDIR);
        q_exp.push_back(DEF | LDBEN);
        case (op)
            1:  q_exp.push_back(DEF | GALU | LDREG | LDCC | (ir5 ? SR2 : 24'h0));
            5:  q_exp.push_back(DEF | GALU | LDREG | LDCC | ALU_AND | (ir5 ? SR2 : 24'h0));
            9:  q_exp.push_back(DEF | GALU | LDREG | LDCC | ALU_NOT);
            0: begin
                q_exp.push_back(DEF);
                if (ben) q_exp.push_back(DEF | A2_OFF9 | PC_ADDR | LDPC);
            end
            12: q_exp.push_back(DEF | A1 | PC_ADDR | LDPC);
            4: begin
                q_exp.push_back(DEF | GPC | DRM | LDREG);
                q_exp.push_back(ir11 ? (DEF | A2_OFF11 | PC_ADDR | LDPC)
                                     : (DEF | A1 | PC_ADDR | LDPC));
            end
            6: begin
                q_exp.push_back(DEF | A1 | A2_OFF6 | GMM | LDMAR);
                q_exp.push_back(RD);
                q_exp.push_back(RD | LDMDR);
                q_exp.push_back(DEF | GMDR | LDREG | LDCC);
            end
            7: begin
                q_exp.push_back(DEF | A1 | A2_OFF6 | GMM | LDMAR);
                q_exp.push_back(DEF | SR1 | ALU_PASS | GALU | LDMDR);
                q_exp.push_back(WR);
                q_exp.push_back(WR);
            end
            default: ;
        endcase
    endfunction

    // Entered with the DUT showing S18; leaves it showing whatever follows the instruction.
    task automatic run_instr(input int op, input bit ir5, input bit ir11, input bit ben);
        Opcode = op[3:0];
        IR_5   = ir5;
        IR_11  = ir11;
        BEN    = ben;
        build(op, ir5, ir11, ben);
        for (int i = 0; i < q_exp.size(); i++) begin
            if (i > 0) begin
                Run = 1'($urandom);
                @(posedge Clk); #1;
            end
            n_cmp++;
            if (w_obs !== q_exp[i]) begin
                n_fail++;
                $display("FAIL instr op=%h cyc=%0d: got %h want %h", op, i, w_obs, q_exp[i]);
            end
        end
        Run = 1'($urandom);
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b1; Continue = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++;
        if (w_obs !== DEF) begin
            n_fail++; $display("FAIL reset_defaults: got %h want %h", w_obs, DEF);
        end
        Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (w_obs !== DEF) begin
                n_fail++; $display("FAIL halted_hold cyc=%0d: got %h want %h", i, w_obs, DEF);
            end
        end
        Run = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        n_cmp++;
        if (w_obs !== FETCH0) begin
            n_fail++; $display("FAIL run_start: got %h want %h", w_obs, FETCH0);
        end
    endtask

    task automatic test_add_imm();
        Continue = 1'b0;
        run_instr(1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (w_obs !== FETCH0) begin
            n_fail++; $display("FAIL add_return: got %h want %h", w_obs, FETCH0);
        end
    endtask

    task automatic test_branch();
        run_instr(0, 1'b0, 1'b0, 1'b1);
        run_instr(0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (w_obs !== FETCH0) begin
            n_fail++; $display("FAIL br_return: got %h want %h", w_obs, FETCH0);
        end
    endtask

    task automatic test_str();
        run_instr(7, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pause(input bit cont_pre);
        Continue = cont_pre;
        run_instr(13, 1'($urandom), 1'($urandom), 1'($urandom));
        n_cmp++;
        if (w_obs !== (DEF | LDLED)) begin
            n_fail++; $display("FAIL pause1_enter: got %h want %h", w_obs, DEF | LDLED);
        end
        if (!cont_pre) begin
            repeat ($urandom_range(1, 4)) begin
                Run = 1'($urandom);
                @(posedge Clk); #1;
                n_cmp++;
                if (w_obs !== (DEF | LDLED)) begin
                    n_fail++; $display("FAIL pause1_hold: got %h want %h", w_obs, DEF | LDLED);
                end
            end
        end
        Continue = 1'b1;
        @(posedge Clk); #1;
        n_cmp++;
        if (w_obs !== DEF) begin
            n_fail++; $display("FAIL pause2_enter: got %h want %h", w_obs, DEF);
        end
        repeat ($urandom_range(0, 3)) begin
            Run = 1'($urandom);
            @(posedge Clk); #1;
            n_cmp++;
            if (w_obs !== DEF) begin
                n_fail++; $display("FAIL pause2_hold: got %h want %h", w_obs, DEF);
            end
        end
        Continue = 1'b0;
        @(posedge Clk); #1;
        n_cmp++;
        if (w_obs !== FETCH0) begin
            n_fail++; $display("FAIL pause_exit: got %h want %h", w_obs, FETCH0);
        end
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if (op == 13) begin
                test_pause(1'($urandom));
            end else begin
                Continue = 1'($urandom);
                run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        Continue = 1'b0;
        n_cmp++;
        if (w_obs !== FETCH0) begin
            n_fail++; $display("FAIL random_end: got %h want %h", w_obs, FETCH0);
        end
    endtask

    task automatic test_reset_mid_ldr();
        Opcode = 4'b0110;
        repeat (6) @(posedge Clk);
        #1;
        n_cmp++;
        if (w_obs !== RD) begin
            n_fail++; $display("FAIL ldr_s25_1: got %h want %h", w_obs, RD);
        end
        Reset = 1'b1; Run = 1'b1; Continue = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
        n_cmp++;
        if (w_obs !== DEF) begin
            n_fail++; $display("FAIL reset_mid_ldr: got %h want %h", w_obs, DEF);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (w_obs !== DEF) begin
                n_fail++; $display("FAIL post_reset_halt cyc=%0d: got %h want %h", i, w_obs, DEF);
            end
        end
        Run = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        n_cmp++;
        if (w_obs !== FETCH0) begin
            n_fail++; $display("FAIL restart: got %h want %h", w_obs, FETCH0);
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_branch();
        test_str();
        test_pause(1'b0);
        test_pause(1'b1);
        run_instr(4, 1'b0, 1'b1, 1'b0);
        run_instr(4, 1'b0, 1'b0, 1'b0);
        run_instr(6, 1'b0, 1'b0, 1'b0);
        test_random(60);
        test_reset_mid_ldr();
        run_instr(5, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/isdu_ctrl.md
# isdu_ctrl

Instruction sequencing and decode unit for the SLC-3 datapath. It is a Moore state machine that fetches, decodes and executes the reduced LC-3 instruction set. It drives every datapath load enable, bus gate, mux select and memory strobe. It consumes `BEN` from the branch-enable stage and tells that stage when to capture condition codes (`LD_CC`) and branch enable (`LD_BEN`).

## Interface
- No parameters.
- `Clk` in 1: system clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high; forces state `HALTED` on the next rising edge.
- `Run` in 1: start request; leaves `HALTED`.
- `Continue` in 1: resumes from pause states.
- `Opcode` in 4: IR[15:12].
- `IR_5` in 1: IR[5], immediate select for ADD/AND.
- `IR_11` in 1: IR[11]; 1 = JSR, 0 = JSRR.
- `BEN` in 1: registered branch enable.
- Load enables, each out 1: `LD_MAR`, `LD_MDR`, `LD_IR`, `LD_BEN`, `LD_CC`, `LD_REG`, `LD_PC`, `LD_LED`.
- Bus gates, each out 1: `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX`.
- `PCMUX` out 2: 00 PC+1, 01 bus, 10 address adder.
- `DRMUX` out 1: 0 IR[11:9], 1 R7.
- `SR1MUX` out 1: 0 IR[8:6], 1 IR[11:9].
- `SR2MUX` out 1: 0 SR2 register, 1 sext(imm5).
- `ADDR1MUX` out 1: 0 PC, 1 SR1.
- `ADDR2MUX` out 2: 00 zero, 01 off6, 10 off9, 11 off11.
- `ALUK` out 2: 00 ADD, 01 AND, 10 NOT, 11 pass A.
- `Mem_OE` out 1: active-low read strobe.
- `Mem_WE` out 1: active-low write strobe.

## Operation
- Outputs depend on the current state only. Defaults in every state: all loads and gates 0, all muxes 0, `Mem_OE` = `Mem_WE` = 1. Each state overrides only what is listed below.
- `HALTED`: moves to `S18` when `Run`=1.
- Fetch:
  - `S18`: GatePC, LD_MAR, PCMUX=00, LD_PC.
  - `S33_1`, `S33_2`: Mem_OE=0. In `S33_2`, also LD_MDR.
  - `S35`: GateMDR, LD_IR.
  - `S32`: LD_BEN. Decode by `Opcode`.
- Decode targets: 0001→`S01`, 0101→`S05`, 1001→`S09`, 0000→`S00`, 1100→`S12`, 0100→`S04`, 0110→`S06`, 0111→`S07`, 1101→`PAUSE1`. Any other opcode goes to `S18` (treated as NOP).
- `S01` ADD / `S05` AND: SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC. Next `S18`.
- `S09` NOT: ALUK=10, GateALU, LD_REG, LD_CC. Next `S18`.
- `S00` BR: if `BEN`=1 go to `S22`, else go to `S18`.
- `S22`: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC. Next `S18`.
- `S12` JMP: ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC. Next `S18`.
- `S04`: GatePC, DRMUX=1, LD_REG. Next `S21` if `IR_11`=1, else `S20`.
  - `S21`: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC.
  - `S20`: same as `S12`.
  - Both return to `S18`.
- LDR:
  - `S06`: ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR.
  - `S25_1`, `S25_2`: Mem_OE=0. In `S25_2`, also LD_MDR.
  - `S27`: GateMDR, LD_REG, LD_CC. Next `S18`.
- STR:
  - `S07`: same as `S06`.
  - `S23`: SR1MUX=1, ALUK=11, GateALU, LD_MDR.
  - `S16_1`, `S16_2`: Mem_WE=0.
  - Next `S18`.
- Pause:
  - `PAUSE1`: LD_LED; stays until `Continue`=1, then `PAUSE2`.
  - `PAUSE2`: stays until `Continue`=0, then `S18`.

## Timing
- Reset: on any rising edge with `Reset`=1, state becomes `HALTED` regardless of the current state, including mid-memory-cycle. This takes priority over `Run` and `Continue`. Outputs take default values from that edge.
- Cycle counts:
  - Fetch plus decode: 5 cycles (`S18`..`S32`).
  - ADD, AND, NOT, JMP, BR not taken: 6 cycles.
  - BR taken, JSR, JSRR: 7 cycles.
  - LDR, STR: 9 cycles.
- `BEN` is sampled in `S00`, the cycle after `LD_BEN` is asserted in `S32`. The upstream stage must register `BEN` on that edge.
- `LD_CC` is always coincident with `LD_REG` when the register write is from an ALU or LDR result. The condition codes therefore reflect the value written to the destination register.
- `Mem_OE` and `Mem_WE` are never low in the same cycle. Each is held low for exactly 2 consecutive cycles per access.
- `Run` is level-sensitive in `HALTED` only and is ignored elsewhere.
- `Continue` is honoured only in the pause states. If `Continue` is held high through `PAUSE1`, the FSM waits in `PAUSE2` until it falls.

## Test plan
- Reset and start: assert `Reset` for 1 cycle → all loads 0, `Mem_OE`=`Mem_WE`=1. Pulse `Run` → states `S18,S33_1,S33_2,S35,S32` on consecutive cycles; `LD_IR`=1 exactly on cycle 4.
- ADD immediate: `Opcode`=0001, `IR_5`=1 → in `S01`: `SR2MUX`=1, `ALUK`=00, `GateALU`=`LD_REG`=`LD_CC`=1; back in `S18` 6 cycles after fetch start.
- Branch: `Opcode`=0000 with `BEN`=1 → `S22`, `PCMUX`=10, `ADDR2MUX`=10, `LD_PC`=1. Repeat with `BEN`=0 → `S18` directly, `LD_PC` never asserted in `S00`.
- STR: `Opcode`=0111 → `Mem_WE`=0 for exactly 2 cycles, with `Mem_OE`=1 throughout; `LD_MDR`=1 with `ALUK`=11 in `S23`.
- Pause handshake: `Opcode`=1101 → `LD_LED`=1 while `Continue`=0. Raise `Continue` → `PAUSE2` (held). Drop `Continue` → `S18` next cycle.
- Reset mid-LDR: assert `Reset` in `S25_1` → `HALTED` on the next edge, `Mem_OE` returns to 1. FSM stays halted until `Run` is asserted.
